// File: rtl/iob_clk_en_rst_gen_if.sv
// ----------------------------------------------------------------------------
// iob_clk_en_rst_gen_if
// Bundles the sequencer's control inputs and reset/enable outputs.
//   lock_i     : clock source ready, asynchronous to the system clock
//   sw_rst_i   : soft reset request, single-cycle pulse in the clock domain
//   cke_div_i  : clock-enable period minus one (0 = enable every cycle)
//   arst_o     : active-high resets, bit 0 released first
//   cke_o      : clock enable pulse
//   ready_o    : high once every reset channel is released
// Modports: master = board/top-level side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface iob_clk_en_rst_gen_if #(
  parameter int N_RST     = 2,
  parameter int CKE_DIV_W = 8
);
  logic                 lock_i;
  logic                 sw_rst_i;
  logic [CKE_DIV_W-1:0] cke_div_i;
  logic [N_RST-1:0]     arst_o;
  logic                 cke_o;
  logic                 ready_o;

  modport master (
    output lock_i,
    output sw_rst_i,
    output cke_div_i,
    input  arst_o,
    input  cke_o,
    input  ready_o
  );

  modport slave (
    input  lock_i,
    input  sw_rst_i,
    input  cke_div_i,
    output arst_o,
    output cke_o,
    output ready_o
  );
endinterface

// File: rtl/iob_clk_en_rst_gen.sv
// ----------------------------------------------------------------------------
// iob_clk_en_rst_gen
// Clock-enable and reset sequencer for FPGA top-levels. After the board reset
// is released and the clock source reports lock, all resets are held for
// HOLD_CYCLES cycles and then released one channel at a time, STAGGER cycles
// apart. A free-running divider produces a programmable-rate clock enable.
//
// Ports:
//   clk_i    : system clock
//   arstn_i  : asynchronous active-low reset (synchronously released inside)
//   bus      : iob_clk_en_rst_gen_if.slave
//              lock_i, sw_rst_i, cke_div_i in; arst_o, cke_o, ready_o out
//
// Configuration macro:
//   IOB_CLK_EN_RST_GEN_SW_RST_EN : when defined, a sw_rst_i pulse in RUN
//   reasserts all resets and reruns the sequence; when undefined sw_rst_i
//   is ignored.
// ----------------------------------------------------------------------------
module iob_clk_en_rst_gen #(
  parameter int N_RST       = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int CKE_DIV_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  iob_clk_en_rst_gen_if.slave  bus
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W  = $clog2(MAX_HS + 1);
  localparam int IDX_W  = (N_RST > 1) ? $clog2(N_RST) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_RST - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Mask with bits 0..k set: channels that are released once index k is out.
  function automatic logic [N_RST-1:0] released_upto(input logic [IDX_W-1:0] k);
    logic [N_RST-1:0] m;
    m = {N_RST{1'b0}};
    for (int i = 0; i < N_RST; i++) begin
      m[i] = (IDX_W'(i) <= k);
    end
    return m;
  endfunction

  logic [1:0]           rst_sync_r;
  logic                 rst_n_s;
  logic [1:0]           lock_sync_r;
  logic                 lock_s;
  logic                 sw_req_s;

  state_t               state_r;
  state_t               state_n;
  logic [CNT_W-1:0]     seq_cnt_r;
  logic [CNT_W-1:0]     seq_cnt_n;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_n;
  logic [N_RST-1:0]     arst_r;
  logic [N_RST-1:0]     arst_n;
  logic                 ready_r;
  logic                 ready_n;

  logic [CKE_DIV_W-1:0] div_cnt_r;
  logic                 cke_r;

  // Reset synchronizer: asserts asynchronously, releases after two edges.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Lock synchronizer, held clear while the internal reset is active.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lock_sync_r <= 2'b00;
    end else if (!rst_n_s) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], bus.lock_i};
    end
  end

  assign lock_s = lock_sync_r[1];

`ifdef IOB_CLK_EN_RST_GEN_SW_RST_EN
  assign sw_req_s = bus.sw_rst_i;
`else
  // The soft reset request is deliberately left unconnected in this build.
  logic sw_rst_unused_s;
  assign sw_rst_unused_s = bus.sw_rst_i;
  assign sw_req_s        = 1'b0;
`endif

  // Sequencer state, counter, channel index and registered outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r   <= WAIT_LOCK;
      seq_cnt_r <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      arst_r    <= {N_RST{1'b1}};
      ready_r   <= 1'b0;
    end else if (!rst_n_s) begin
      state_r   <= WAIT_LOCK;
      seq_cnt_r <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      arst_r    <= {N_RST{1'b1}};
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      seq_cnt_r <= seq_cnt_n;
      idx_r     <= idx_n;
      arst_r    <= arst_n;
      ready_r   <= ready_n;
    end
  end

  // Next-state logic. Lock loss is tested first so it wins over sw_rst_i.
  // Output bits are computed here for the next edge so they stay registered.
  always_comb begin
    state_n   = state_r;
    seq_cnt_n = seq_cnt_r;
    idx_n     = idx_r;
    arst_n    = arst_r;
    ready_n   = ready_r;

    case (state_r)
      WAIT_LOCK: begin
        arst_n  = {N_RST{1'b1}};
        ready_n = 1'b0;
        if (lock_s) begin
          state_n   = HOLD;
          seq_cnt_n = {CNT_W{1'b0}};
        end else begin
          state_n   = WAIT_LOCK;
        end
      end

      HOLD: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          seq_cnt_n = {CNT_W{1'b0}};
          idx_n     = {IDX_W{1'b0}};
          arst_n    = {N_RST{1'b1}};
          ready_n   = 1'b0;
        end else if (seq_cnt_r == HOLD_LAST) begin
          // Channel 0 is released on the same edge RELEASE is entered.
          state_n   = RELEASE;
          seq_cnt_n = {CNT_W{1'b0}};
          idx_n     = {IDX_W{1'b0}};
          arst_n    = ~released_upto({IDX_W{1'b0}});
        end else begin
          seq_cnt_n = seq_cnt_r + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          seq_cnt_n = {CNT_W{1'b0}};
          idx_n     = {IDX_W{1'b0}};
          arst_n    = {N_RST{1'b1}};
          ready_n   = 1'b0;
        end else if (idx_r == IDX_LAST) begin
          // Last channel went out on the previous edge.
          state_n   = RUN;
          ready_n   = 1'b1;
        end else if (seq_cnt_r == STAGGER_LAST) begin
          idx_n     = idx_r + IDX_W'(1);
          seq_cnt_n = {CNT_W{1'b0}};
          arst_n    = ~released_upto(idx_r + IDX_W'(1));
        end else begin
          seq_cnt_n = seq_cnt_r + CNT_W'(1);
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          seq_cnt_n = {CNT_W{1'b0}};
          idx_n     = {IDX_W{1'b0}};
          arst_n    = {N_RST{1'b1}};
          ready_n   = 1'b0;
        end else if (sw_req_s) begin
          state_n   = HOLD;
          seq_cnt_n = {CNT_W{1'b0}};
          idx_n     = {IDX_W{1'b0}};
          arst_n    = {N_RST{1'b1}};
          ready_n   = 1'b0;
        end else begin
          state_n   = RUN;
        end
      end

      default: begin
        state_n   = WAIT_LOCK;
        seq_cnt_n = {CNT_W{1'b0}};
        idx_n     = {IDX_W{1'b0}};
        arst_n    = {N_RST{1'b1}};
        ready_n   = 1'b0;
      end
    endcase
  end

  // Clock-enable divider. Comparing with >= rather than == means a divisor
  // lowered below the current count pulses on the next edge instead of
  // wrapping through the full counter range.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_cnt_r <= {CKE_DIV_W{1'b0}};
      cke_r     <= 1'b0;
    end else if (!rst_n_s) begin
      div_cnt_r <= {CKE_DIV_W{1'b0}};
      cke_r     <= 1'b0;
    end else if (div_cnt_r >= bus.cke_div_i) begin
      div_cnt_r <= {CKE_DIV_W{1'b0}};
      cke_r     <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + CKE_DIV_W'(1);
      cke_r     <= 1'b0;
    end
  end

  assign bus.arst_o  = arst_r;
  assign bus.cke_o   = cke_r;
  assign bus.ready_o = ready_r;

endmodule

// File: tb/tb_iob_clk_en_rst_gen.sv
// ----------------------------------------------------------------------------
// tb_iob_clk_en_rst_gen
// Self-checking bench for iob_clk_en_rst_gen (N_RST=3, HOLD_CYCLES=16,
// STAGGER=4). Edge e=0 is the first clock edge that samples arstn high.
// The reference model states the release schedule as formulas over e and
// the edge at which the current sequence started.
// ----------------------------------------------------------------------------
module tb_iob_clk_en_rst_gen;

  localparam int N  = 3;
  localparam int H  = 16;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int LAST_FALL = H + (N - 1) * S;

`ifdef IOB_CLK_EN_RST_GEN_SW_RST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic arstn = 1'b1;

  always #5 clk = ~clk;

  iob_clk_en_rst_gen_if #(.N_RST(N), .CKE_DIV_W(DW)) bus ();

  iob_clk_en_rst_gen #(
    .N_RST(N), .HOLD_CYCLES(H), .STAGGER(S), .CKE_DIV_W(DW)
  ) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge.
  logic          smp_lock = 1'b0;
  logic          smp_sw   = 1'b0;
  logic [DW-1:0] smp_div  = 8'd0;
  always @(posedge clk) begin
    smp_lock <= bus.lock_i;
    smp_sw   <= bus.sw_rst_i;
    smp_div  <= bus.cke_div_i;
  end

  // Model state: edge number, running sequence flag and start edge, divider.
  int  e_m      = -1;
  bit  seq_on_m = 1'b0;
  int  sstart_m = 0;
  int  dc_m     = 0;
  bit  cke_m    = 1'b0;
  bit  lock_hist [4096];

  // Reference model plus the single per-cycle compare process.
  initial begin
    logic          lk;
    logic [N-1:0]  ea;
    logic          er;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        e_m      = -1;
        seq_on_m = 1'b0;
        dc_m     = 0;
        cke_m    = 1'b0;
      end else begin
        e_m++;
        lock_hist[e_m % 4096] = smp_lock;
        // Lock is seen by the sequencer two edges after capture; capture
        // starts once the internal reset is out (edge 2).
        lk = 1'b0;
        if (e_m >= 4) lk = lock_hist[(e_m - 2) % 4096];
        if (e_m >= 2) begin
          if (dc_m >= int'(smp_div)) begin
            dc_m  = 0;
            cke_m = 1'b1;
          end else begin
            dc_m++;
            cke_m = 1'b0;
          end
          if (seq_on_m && !lk) begin
            seq_on_m = 1'b0;
          end else if (!seq_on_m && lk) begin
            seq_on_m = 1'b1;
            sstart_m = e_m;
          end else if (seq_on_m && SW_EN && smp_sw && (e_m - 1) >= sstart_m + LAST_FALL + 1) begin
            sstart_m = e_m;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        ea[k] = !(seq_on_m && e_m >= sstart_m + H + k * S);
      end
      er = seq_on_m && (e_m >= sstart_m + LAST_FALL + 1);
      check("model_arst", 32'(bus.arst_o), 32'(ea));
      check("model_ready", 32'(bus.ready_o), 32'(er));
      check("model_cke", 32'(bus.cke_o), 32'(cke_m));
    end
  end

  // Advance to just after the negedge at which the model reaches edge t.
  task automatic wait_e(input int t);
    int n;
    n = 0;
    while (e_m != t && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (e_m != t) begin
      checks++;
      errors++;
      $display("FAIL wait_e: edge %0d reached, wanted %0d", e_m, t);
    end
  endtask

  initial begin
    int x;
    int d;
    int l;
    bus.lock_i    = 1'b1;
    bus.sw_rst_i  = 1'b0;
    bus.cke_div_i = 8'd0;
    #2 arstn = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_arst", 32'(bus.arst_o), 32'd7);
    check("rst_cke", 32'(bus.cke_o), 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    arstn = 1'b1;

    // Power-up schedule with lock already high.
    wait_e(1);  check("cke_e1", 32'(bus.cke_o), 32'd0);
    wait_e(2);  check("cke_e2", 32'(bus.cke_o), 32'd1);
    wait_e(19); check("pu_arst19", 32'(bus.arst_o), 32'd7);
    wait_e(20); check("pu_arst20", 32'(bus.arst_o), 32'd6);
    wait_e(23); check("pu_arst23", 32'(bus.arst_o), 32'd6);
    wait_e(24); check("pu_arst24", 32'(bus.arst_o), 32'd4);
    wait_e(28); check("pu_arst28", 32'(bus.arst_o), 32'd0);
                check("pu_ready28", 32'(bus.ready_o), 32'd0);
    wait_e(29); check("pu_ready29", 32'(bus.ready_o), 32'd1);

    // Divider: 0 -> 3 gives a pulse every 4 edges.
    bus.cke_div_i = 8'd3;
    x = e_m;
    wait_e(x + 3); check("div3_e3", 32'(bus.cke_o), 32'd0);
    wait_e(x + 4); check("div3_e4", 32'(bus.cke_o), 32'd1);
    wait_e(x + 8); check("div3_e8", 32'(bus.cke_o), 32'd1);

    // Divider: 7, then 2 while the count is 5 -> immediate pulse, then every 3.
    bus.cke_div_i = 8'd7;
    d = 0;
    while (dc_m != 5 && d < 40) begin
      @(negedge clk);
      #1;
      d++;
    end
    check("div_cnt5_reached", 32'(dc_m), 32'd5);
    bus.cke_div_i = 8'd2;
    x = e_m;
    wait_e(x + 1); check("div2_p1", 32'(bus.cke_o), 32'd1);
    wait_e(x + 2); check("div2_p2", 32'(bus.cke_o), 32'd0);
    wait_e(x + 3); check("div2_p3", 32'(bus.cke_o), 32'd0);
    wait_e(x + 4); check("div2_p4", 32'(bus.cke_o), 32'd1);

    // Soft reset pulse in RUN.
    bus.sw_rst_i = 1'b1;
    x = e_m + 1;
    wait_e(x);
    bus.sw_rst_i = 1'b0;
    check("sw_arst0", 32'(bus.arst_o), SW_EN ? 32'd7 : 32'd0);
    check("sw_ready0", 32'(bus.ready_o), SW_EN ? 32'd0 : 32'd1);
    wait_e(x + 16); check("sw_arst16", 32'(bus.arst_o), SW_EN ? 32'd6 : 32'd0);
    wait_e(x + 25); check("sw_ready25", 32'(bus.ready_o), 32'd1);

    // Lock loss in RUN: all resets back after three edges.
    bus.lock_i = 1'b0;
    d = e_m + 1;
    wait_e(d + 1); check("ll_run_arst2", 32'(bus.arst_o), 32'd0);
    wait_e(d + 2); check("ll_run_arst3", 32'(bus.arst_o), 32'd7);
                   check("ll_run_ready3", 32'(bus.ready_o), 32'd0);
    wait_e(d + 12);

    // Re-lock; a soft reset pulse during HOLD changes nothing.
    bus.lock_i = 1'b1;
    l = e_m + 1;
    wait_e(l + 4);
    bus.sw_rst_i = 1'b1;
    wait_e(l + 5);
    bus.sw_rst_i = 1'b0;
    wait_e(l + 17); check("relock_arst17", 32'(bus.arst_o), 32'd7);
    wait_e(l + 18); check("relock_arst18", 32'(bus.arst_o), 32'd6);
    wait_e(l + 27); check("relock_ready", 32'(bus.ready_o), 32'd1);

    // Lock loss mid-RELEASE, after bit 0 has cleared.
    bus.lock_i = 1'b0;
    d = e_m + 1;
    wait_e(d + 3);
    bus.lock_i = 1'b1;
    l = e_m + 1;
    wait_e(l + 19); check("mid_arst", 32'(bus.arst_o), 32'd6);
    bus.lock_i = 1'b0;
    d = e_m + 1;
    wait_e(d + 1); check("ll_rel_arst2", 32'(bus.arst_o), 32'd6);
    wait_e(d + 2); check("ll_rel_arst3", 32'(bus.arst_o), 32'd7);
    bus.lock_i = 1'b1;
    l = e_m + 1;
    wait_e(l + 19); check("mid2_arst", 32'(bus.arst_o), 32'd6);

    // arstn asserted mid-RELEASE acts without a clock edge.
    #2 arstn = 1'b0;
    #1;
    check("async_arst", 32'(bus.arst_o), 32'd7);
    check("async_cke", 32'(bus.cke_o), 32'd0);
    check("async_ready", 32'(bus.ready_o), 32'd0);
    bus.lock_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 arstn = 1'b1;

    // Lock held low for 100 cycles after reset, then raised.
    wait_e(100); check("nolock_arst", 32'(bus.arst_o), 32'd7);
                 check("nolock_ready", 32'(bus.ready_o), 32'd0);
    bus.lock_i = 1'b1;
    wait_e(118); check("late_arst118", 32'(bus.arst_o), 32'd7);
    wait_e(119); check("late_arst119", 32'(bus.arst_o), 32'd6);
    wait_e(127); check("late_arst127", 32'(bus.arst_o), 32'd0);
    wait_e(128); check("late_ready128", 32'(bus.ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_clk_en_rst_gen.md
# iob_clk_en_rst_gen

Parametrised clock-enable and reset sequencer for FPGA top-levels. It takes the board or processing-system reset and a clock-source "ready" indication, and produces N_RST staggered, synchronously released active-high resets plus a programmable-rate clock enable for the SoC core and its interconnect. It replaces the hard-wired `cke = 1` and `arst = ~arstn` glue in board wrappers.

## Interface
- N_RST, 2: number of reset outputs, released in index order (>=1)
- HOLD_CYCLES, 16: cycles all resets stay asserted after lock is seen (>=1)
- STAGGER, 4: cycles between consecutive channel releases (>=1)
- CKE_DIV_W, 8: width of clock-enable divider input
- clk_i  input  1  system clock
- arstn_i  input  1  asynchronous active-low reset
- lock_i  input  1  clock source ready (PLL lock / PS ready); asynchronous to clk_i
- sw_rst_i  input  1  soft reset request, single-cycle pulse, clk_i domain
- cke_div_i  input  CKE_DIV_W  clock-enable period minus one; 0 = enable every cycle
- arst_o  output  N_RST  active-high resets; bit 0 released first
- cke_o  output  1  clock enable
- ready_o  output  1  high when all resets are released

## Operation
- arstn_i low: asynchronously forces arst_o = all ones, cke_o = 0, ready_o = 0, FSM to WAIT_LOCK, and all counters to 0.
- arstn_i release passes through an internal 2-FF synchronizer. lock_i passes through a 2-FF synchronizer (lock_s), held in reset by the synchronized reset.
- FSM states: WAIT_LOCK, HOLD, RELEASE, RUN.
  - WAIT_LOCK: arst_o all ones. When lock_s = 1, go to HOLD and clear the counter.
  - HOLD: count HOLD_CYCLES cycles, then go to RELEASE with the channel index at 0.
  - RELEASE: clear arst_o[idx]. After STAGGER cycles, increment idx. After arst_o[N_RST-1] clears, go to RUN.
  - RUN: ready_o = 1.
- Lock loss: in HOLD, RELEASE or RUN, lock_s = 0 sets arst_o to all ones and ready_o to 0 on the next edge, and the FSM goes to WAIT_LOCK.
- Soft reset: sw_rst_i = 1 in RUN sets arst_o to all ones and ready_o to 0 on the next edge. The FSM goes to HOLD and the full sequence reruns. sw_rst_i is ignored in all other states.
- Precedence: lock loss beats sw_rst_i when both occur in the same cycle.
- Resets always assert together. They release only in index order; once released, a channel stays released until the next reassertion of all channels.
- Clock-enable divider: CKE_DIV_W-bit counter `cnt`, free-running once the synchronized reset is released, independent of the FSM.
  - If cnt >= cke_div_i: set cnt to 0 and cke_o to 1 (registered).
  - Otherwise: increment cnt and set cke_o to 0.
  - A change of cke_div_i takes effect without glitches. If the new value is below the current cnt, the next cycle pulses.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER) + 1). There is no wrap-around in HOLD or RELEASE.

## Timing
- Reset values: arst_o = {N_RST{1'b1}}, cke_o = 0, ready_o = 0.
- Reference point T0 is the first clk_i edge sampling arstn_i high, with lock_i stable high.
  - arst_o[k] falls at T0 + 4 + HOLD_CYCLES + k*STAGGER.
  - ready_o rises at T0 + 5 + HOLD_CYCLES + (N_RST-1)*STAGGER.
- From lock_i falling to arst_o all ones takes 3 edges (2 for synchronization, 1 registered).
- From the sw_rst_i sample to arst_o all ones takes 1 edge. The channels then re-release at the same offsets, measured from that edge with HOLD counted.
- With cke_div_i = 0, cke_o is 1 from the second edge after reset release onward. With cke_div_i = D, cke_o is a 1-cycle pulse every D+1 cycles.
- All outputs are registered. No combinational path from input to output.

## Configuration
- IOB_CLK_EN_RST_GEN_SW_RST_EN
  - Defined: soft-reset behaviour as specified.
  - Undefined: sw_rst_i remains a port but is ignored, and the FSM leaves RUN only on lock loss or arstn_i.

## Test plan
- Power-up (N_RST=3, HOLD_CYCLES=16, STAGGER=4, lock_i high) -> arst_o bits fall at T0+20, +24 and +28; ready_o rises at T0+29.
- lock_i held low for 100 cycles after reset, then raised -> arst_o stays 3'b111 and ready_o stays 0 until the rise; then the sequence is as above, offset by the synchronizer.
- lock_i dropped in RUN, and separately mid-RELEASE (after bit 0 clears) -> arst_o = 3'b111 within 3 cycles and ready_o = 0; re-lock reruns the full sequence.
- sw_rst_i pulse in RUN -> arst_o = 3'b111 next cycle, then re-release at +16/+20/+24 cycles; a pulse during HOLD has no effect; with the macro undefined, a pulse in RUN has no effect.
- cke_div_i = 0, then 3, then switched from 7 to 2 while cnt = 5 -> cke_o is constant 1; then one pulse every 4 cycles; then a pulse on the next cycle followed by one every 3 cycles.
- arstn_i asserted mid-RELEASE -> arst_o = all ones, cke_o = 0 and ready_o = 0 immediately, without waiting for a clock edge.
